// File: rtl/aes_decryption.sv
`default_nettype none
// ============================================================================
// Module   : aes_decryption
// Purpose  : Iterative AES-128 inverse cipher with a byte-serial load/unload
//            interface; one key-expansion step or one round per enabled cycle.
// Revision : 1.0  initial release
// ============================================================================
module aes_decryption (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] key_byte,
  input  logic [7:0] cipher_byte,
  output logic       load,
  output logic       ready,
  output logic [7:0] plain_byte_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KEXP   = 3'd2,
    S_ROUND  = 3'd3,
    S_UNLOAD = 3'd4
  } fsmState_t;

  localparam logic [3:0] c_lastByte  = 4'd15;
  localparam logic [3:0] c_lastRound = 4'd10;
  localparam logic [4:0] c_outDone   = 5'd16;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gfMul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] subByte(input logic [7:0] x);
    logic [7:0] i;
    i = gfInv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSubByte(input logic [7:0] x);
    return gfInv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = invSubByte(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0,8'h0e) ^ gfMul(a1,8'h0b) ^ gfMul(a2,8'h0d) ^ gfMul(a3,8'h09);
      o[119-32*c -: 8] = gfMul(a0,8'h09) ^ gfMul(a1,8'h0e) ^ gfMul(a2,8'h0b) ^ gfMul(a3,8'h0d);
      o[111-32*c -: 8] = gfMul(a0,8'h0d) ^ gfMul(a1,8'h09) ^ gfMul(a2,8'h0e) ^ gfMul(a3,8'h0b);
      o[103-32*c -: 8] = gfMul(a0,8'h0b) ^ gfMul(a1,8'h0d) ^ gfMul(a2,8'h09) ^ gfMul(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] keyExpand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {subByte(prev[23:16]), subByte(prev[15:8]), subByte(prev[7:0]), subByte(prev[31:24])}
         ^ {rc, 24'h000000};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsmState_t    r_fsm;
  fsmState_t    w_nextState;
  logic [3:0]   r_cnt;
  logic [3:0]   r_kcnt;
  logic [3:0]   r_round;
  logic [4:0]   r_ocnt;
  logic [127:0] r_state;
  logic [127:0] r_cipher;
  logic [127:0] r_rk [0:10];

  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic [127:0] w_nextKey;

  assign w_ark     = invSubBytes(invShiftRows(r_state)) ^ r_rk[c_lastRound - r_round];
  assign w_imc     = invMixColumns(w_ark);
  assign w_nextKey = keyExpand(r_rk[r_kcnt - 4'd1], rcon(r_kcnt));

  always_comb begin
    w_nextState = r_fsm;
    case (r_fsm)
      S_IDLE:   w_nextState = S_LOAD;
      S_LOAD:   if (r_cnt == c_lastByte)    w_nextState = S_KEXP;
      S_KEXP:   if (r_kcnt == c_lastRound)  w_nextState = S_ROUND;
      S_ROUND:  if (r_round == c_lastRound) w_nextState = S_UNLOAD;
      S_UNLOAD: if (r_ocnt == c_outDone)    w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm          <= S_IDLE;
      load           <= 1'b0;
      ready          <= 1'b0;
      plain_byte_out <= 8'h00;
      r_cnt          <= '0;
      r_kcnt         <= '0;
      r_round        <= '0;
      r_ocnt         <= '0;
      r_state        <= '0;
      r_cipher       <= '0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else if (enable) begin
      r_fsm <= w_nextState;
      case (r_fsm)
        S_IDLE: begin
          load  <= 1'b1;
          r_cnt <= '0;
        end
        S_LOAD: begin
          // Key arrives MSB-first straight into rk[0]; cipher arrives LSB-first.
          r_rk[0][{~r_cnt, 3'b111} -: 8] <= key_byte;
          r_cipher[{r_cnt, 3'b000} +: 8] <= cipher_byte;
          if (r_cnt == c_lastByte) begin
            load   <= 1'b0;
            r_kcnt <= 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_KEXP: begin
          r_rk[r_kcnt] <= w_nextKey;
          if (r_kcnt == c_lastRound) r_round <= '0;
          else                       r_kcnt  <= r_kcnt + 4'd1;
        end
        S_ROUND: begin
          if (r_round == 4'd0) begin
            r_state <= r_cipher ^ r_rk[10];
            r_round <= r_round + 4'd1;
          end else if (r_round == c_lastRound) begin
            r_state        <= w_ark;
            ready          <= 1'b1;
            plain_byte_out <= w_ark[127:120];
            r_ocnt         <= 5'd1;
          end else begin
            r_state <= w_imc;
            r_round <= r_round + 4'd1;
          end
        end
        S_UNLOAD: begin
          if (r_ocnt == c_outDone) begin
            ready <= 1'b0;
          end else begin
            plain_byte_out <= r_state[{~r_ocnt[3:0], 3'b111} -: 8];
            r_ocnt         <= r_ocnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_decryption.sv
`default_nettype none
// Bench for aes_decryption: known-answer vectors, loopback against an AES
// encrypt model, stalls, mid-operation reset and back-to-back blocks.
module tb_aes_decryption;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic [7:0] cipher_byte = 8'h00;
  logic       load;
  logic       ready;
  logic [7:0] plain_byte_out;

  aes_decryption dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .key_byte       (key_byte),
    .cipher_byte    (cipher_byte),
    .load           (load),
    .ready          (ready),
    .plain_byte_out (plain_byte_out)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [7:0]   q[$];
  logic [127:0] curKey;
  logic [127:0] curCipher;
  int           loadIdx;
  int           enEdges;
  int           ticks;
  bit           sawReady;
  logic [7:0]   sbox [256];
  logic [2047:0] sboxBits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference forward cipher, used to produce loopback ciphertext.
  function automatic logic [127:0] aesEnc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ key[127-8*j -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int j = 0; j < 16; j++) t[j] = sbox[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rd+c][31-8*r -: 8];
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  // One clock: drive inputs, score a byte the consumer takes, then sample.
  task automatic tick(input logic en);
    enable = en;
    if (load && en && loadIdx < 16) begin
      key_byte    = curKey[127-8*loadIdx -: 8];
      cipher_byte = curCipher[8*loadIdx +: 8];
      loadIdx++;
    end else begin
      key_byte    = 8'($urandom);
      cipher_byte = 8'($urandom);
    end
    if (ready && en) begin
      if (q.size() == 0) check("extra_byte", 32'd1, 32'd0);
      else check("plain", {24'h0, plain_byte_out}, {24'h0, q.pop_front()});
    end
    @(posedge clk);
    #1;
    if (en) enEdges++;
    ticks++;
    check("load_phase", {31'h0, load}, {31'h0, (enEdges >= 1 && enEdges <= 16)});
    check("ready_phase", {31'h0, ready}, {31'h0, (enEdges >= 38 && enEdges <= 53)});
    if (!en && ready && q.size() > 0)
      check("held_byte", {24'h0, plain_byte_out}, {24'h0, q[0]});
    if (ready && !sawReady) begin
      sawReady = 1'b1;
      check("latency", enEdges, 38);
    end
  endtask

  task automatic runBlock(input logic [127:0] key, input logic [127:0] cipher,
                          input logic [127:0] plain, input bit stall, input int abortAt);
    int stalledAt;
    curKey    = key;
    curCipher = cipher;
    loadIdx   = 0;
    enEdges   = 0;
    ticks     = 0;
    sawReady  = 1'b0;
    stalledAt = -1;
    for (int i = 0; i < 16; i++) q.push_back(plain[127-8*i -: 8]);
    while (enEdges < 54 && ticks < 200) begin
      if (abortAt != 0 && enEdges == abortAt) begin
        #2 rst = 1'b0;
        #1;
        check("rst_load", {31'h0, load}, 32'd0);
        check("rst_ready", {31'h0, ready}, 32'd0);
        check("rst_byte", {24'h0, plain_byte_out}, 32'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      if (stall && stalledAt != enEdges &&
          (enEdges == 5 || enEdges == 20 || enEdges == 30 || enEdges == 45)) begin
        stalledAt = enEdges;
        repeat (3) tick(1'b0);
      end else begin
        tick(1'b1);
      end
    end
    check("period", ticks, stall ? 66 : 54);
    check("drained", q.size(), 0);
  endtask

  localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PLAIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CIPHER  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PLAIN   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] lbKey;
    logic [127:0] lbPlain;
    sboxBits = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sboxBits[2047-8*i -: 8];

    repeat (2) @(posedge clk);
    #1;
    check("reset_load", {31'h0, load}, 32'd0);
    check("reset_ready", {31'h0, ready}, 32'd0);
    check("reset_byte", {24'h0, plain_byte_out}, 32'd0);
    rst = 1'b1;

    // C.1 then B back to back with enable continuous.
    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b0, 0);
    runBlock(B_KEY, B_CIPHER, B_PLAIN, 1'b0, 0);

    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b1, 0);

    lbKey   = {$urandom, $urandom, $urandom, $urandom};
    lbPlain = {$urandom, $urandom, $urandom, $urandom};
    runBlock(lbKey, aesEnc(lbKey, lbPlain), lbPlain, 1'b0, 0);

    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b0, 32);
    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b0, 0);
    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b0, 45);
    runBlock(C1_KEY, C1_CIPHER, C1_PLAIN, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
